// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, error codes,
// common keyboard commands and the default bus timing.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } tx_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NOACK   = 2'b10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  localparam int DEF_CLK_FREQ_HZ = 50_000_000;
  localparam int DEF_FILTER_LEN  = 8;
  localparam int INHIBIT_US      = 100;
  localparam int REQ_US          = 5;
  localparam int TIMEOUT_US      = 15_000;

  // Microseconds to system clock cycles (frequency is a whole number of MHz).
  function automatic int us_to_cycles(input int freq_hz, input int us);
    return (freq_hz / 1_000_000) * us;
  endfunction

  // Ten-bit frame shifted out LSB-first: data, odd parity, stop.
  function automatic logic [9:0] frame_word(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes one raw PS/2 line and debounces it with a run-length filter:
// the filtered value only changes after FILTER_LEN consecutive samples that
// disagree with it. Also emits a one-cycle strobe on a filtered 1->0 edge.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line_filt,
  output logic line_fall
);

  localparam int RW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [RW-1:0] RUN_LAST = RW'(FILTER_LEN - 1);

  logic [1:0]    sync;
  logic [RW-1:0] run;

  // Two-stage synchronizer feeding the run-length filter; idle bus reads high.
  // NOTE: every register here uses non-blocking assignment so all stages
  // update from the same pre-edge values and the chain really is two flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync      <= 2'b11;
      line_filt <= 1'b1;
      run       <= '0;
      line_fall <= 1'b0;
    end else begin
      sync      <= {sync[0], line_in};
      line_fall <= 1'b0;
      if (sync[1] != line_filt) begin
        if (run == RUN_LAST) begin
          line_filt <= sync[1];
          line_fall <= ~sync[1];
          run       <= '0;
        end else begin
          run <= run + 1'b1;
        end
      end else begin
        run <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: accepts one command byte, performs the
// clock-inhibit / request-to-send sequence, clocks out data, parity and stop
// on device clock falls, checks the device ACK and reports done or error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = DEF_CLK_FREQ_HZ,
  parameter int INHIBIT_CYCLES = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US),
  parameter int REQ_CYCLES     = us_to_cycles(CLK_FREQ_HZ, REQ_US),
  parameter int TIMEOUT_CYCLES = us_to_cycles(CLK_FREQ_HZ, TIMEOUT_US),
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code
);

  localparam int PHASE_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int PW = $clog2(PHASE_MAX);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] INH_LAST = PW'(INHIBIT_CYCLES - 1);
  localparam logic [PW-1:0] REQ_LAST = PW'(REQ_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic clk_filt, clk_fall;
  logic dat_filt, dat_fall_unused;

  tx_state_t     state;
  logic [9:0]    shift;
  logic [3:0]    bit_cnt;
  logic [PW-1:0] phase_cnt;
  logic [TW-1:0] tout_cnt;

  logic       timed;
  logic       err_now;
  logic [1:0] err_sel;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk       (clk),
    .reset     (reset),
    .line_in   (ps2_clk_in),
    .line_filt (clk_filt),
    .line_fall (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk       (clk),
    .reset     (reset),
    .line_in   (ps2_dat_in),
    .line_filt (dat_filt),
    .line_fall (dat_fall_unused)
  );

  // Once the device owns the clock, a stalled device or a missing ACK aborts.
  assign timed   = (state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE);
  assign err_now = timed && ((!clk_fall && tout_cnt == TO_LAST) ||
                             (state == S_ACK && clk_fall && dat_filt));
  assign err_sel = clk_fall ? ERR_NOACK : ERR_TIMEOUT;

  // Transmit sequencer with all bus and status outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      phase_cnt  <= '0;
      tout_cnt   <= '0;
      tx_ready   <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      if (timed) tout_cnt <= clk_fall ? '0 : tout_cnt + 1'b1;

      if (err_now) begin
        err_code   <= err_sel;
        tx_err     <= 1'b1;
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
        tx_busy    <= 1'b0;
        state      <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (tx_valid && tx_ready) begin
              shift      <= frame_word(tx_data);
              err_code   <= ERR_NONE;
              phase_cnt  <= '0;
              ps2_clk_oe <= 1'b1;
              tx_ready   <= 1'b0;
              tx_busy    <= 1'b1;
              state      <= S_INHIBIT;
            end else begin
              tx_ready <= clk_filt & dat_filt;
            end
          end
          S_INHIBIT: begin
            if (phase_cnt == INH_LAST) begin
              phase_cnt  <= '0;
              ps2_dat_oe <= 1'b1;
              state      <= S_REQ;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
          S_REQ: begin
            if (phase_cnt == REQ_LAST) begin
              ps2_clk_oe <= 1'b0;
              tout_cnt   <= '0;
              bit_cnt    <= '0;
              state      <= S_SEND;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
          S_SEND: begin
            if (clk_fall) begin
              ps2_dat_oe <= ~shift[0];
              shift      <= {1'b0, shift[9:1]};
              bit_cnt    <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd9) state <= S_ACK;
            end
          end
          S_ACK: begin
            if (clk_fall) state <= S_WAIT_IDLE;
          end
          S_WAIT_IDLE: begin
            if (clk_filt && dat_filt) begin
              tx_done <= 1'b1;
              tx_busy <= 1'b0;
              state   <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-drain PS/2 device model.
// Timing parameters are scaled down so the whole run stays short.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 50;
  localparam int REQ  = 10;
  localparam int TO   = 2000;
  localparam int FL   = 4;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       tx_busy, tx_done, tx_err;
  logic [1:0] err_code;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_in, ps2_dat_in;

  // Wired-AND open-drain bus shared by host and device.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_FREQ_HZ    (50_000_000),
    .INHIBIT_CYCLES (INH),
    .REQ_CYCLES     (REQ),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .err_code   (err_code)
  );

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int acc_cnt = 0;

  // Event counters sampled at the active edge, before the DUT updates.
  always @(posedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) err_cnt <= err_cnt + 1;
    if (tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    logic [9:0] exp_bits;
    logic [1:0] exp_err;
    int         exp_done;
  } vec_t;

  // Offer a byte and return on the first negedge after it was accepted.
  task automatic send(input logic [7:0] d);
    int n;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_busy && n < 500);
    tx_valid = 1'b0;
    check("accept", tx_busy, 1);
  endtask

  // Device: clocks n_edges falls, samples host DAT on each rising edge,
  // and on the 11th clock drives the ACK (or leaves DAT high).
  task automatic dev_run(input int n_edges, input bit ack, output logic [9:0] bits);
    bits = '0;
    repeat (HALF) @(negedge clk);
    for (int e = 1; e <= n_edges && e <= 10; e++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      bits[e-1] = ps2_dat_in;
      repeat (HALF) @(negedge clk);
    end
    if (n_edges >= 11) begin
      dev_dat = ~ack;
      repeat (HALF / 2) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_dat = 1'b1;
    end
  endtask

  task automatic wait_release();
    int n = 0;
    while (ps2_clk_oe && n < INH + REQ + 100) begin
      @(negedge clk);
      n++;
    end
    check("clk_released", ps2_clk_oe, 0);
  endtask

  task automatic do_transfer(input string tag, input vec_t v);
    int n, d0, e0;
    logic [9:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    send(v.data);
    check({tag, "_err_cleared"}, err_code, 2'b00);
    n = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n < INH + 50) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_inhibit_len"}, n, INH);
    n = 0;
    while (ps2_clk_oe && ps2_dat_oe && n < REQ + 50) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_req_len"}, n, REQ);
    dev_run(11, v.ack, bits);
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check({tag, "_bits"}, bits, v.exp_bits);
    check({tag, "_done"}, done_cnt - d0, v.exp_done);
    check({tag, "_err_pulse"}, err_cnt - e0, 1 - v.exp_done);
    check({tag, "_err_code"}, err_code, v.exp_err);
    check({tag, "_oe_idle"}, {ps2_clk_oe, ps2_dat_oe, tx_busy}, 3'b000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    vec_t vf4;
    logic [9:0] bits;
    int n, a0, d0, e0, rdy;

    vecs[0] = '{CMD_SET_LEDS, 1'b1, 10'h3ED, 2'b00, 1};
    vecs[1] = '{8'h00,        1'b1, 10'h300, 2'b00, 1};
    vecs[2] = '{8'h01,        1'b1, 10'h201, 2'b00, 1};
    vecs[3] = '{CMD_SET_LEDS, 1'b0, 10'h3ED, 2'b10, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outputs", {ps2_clk_oe, ps2_dat_oe, tx_ready, tx_busy, tx_done, tx_err},
          6'b000000);
    check("rst_err_code", err_code, 2'b00);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_ready", tx_ready, 1);

    // Table-driven transfers
    for (int i = 0; i < 4; i++) begin
      do_transfer($sformatf("vec%0d", i), vecs[i]);
      repeat (5) @(negedge clk);
    end

    // Device never clocks: timeout measured from CLK release
    d0 = done_cnt;
    send(CMD_RESET);
    check("to_err_cleared", err_code, 2'b00);
    wait_release();
    n = 0;
    while (!tx_err && n < TO + 100) begin
      n++;
      @(negedge clk);
    end
    check("to_latency", n, TO);
    check("to_err_code", err_code, 2'b01);
    check("to_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    repeat (3) @(negedge clk);
    check("to_no_done", done_cnt - d0, 0);

    // Reset in the data phase after the 4th clock fall
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h00);
    wait_release();
    dev_run(4, 1'b1, bits);
    check("mid_dat_driven", ps2_dat_oe, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_oe", {ps2_clk_oe, ps2_dat_oe, tx_busy}, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
    vf4 = '{CMD_ENABLE, 1'b1, 10'h2F4, 2'b00, 1};
    do_transfer("f4", vf4);

    // tx_valid while the device holds CLK low, then a second offer mid-transfer
    a0 = acc_cnt;
    d0 = done_cnt;
    @(negedge clk);
    dev_clk = 1'b0;
    repeat (20) @(negedge clk);
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    rdy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_ready || tx_busy) rdy++;
    end
    check("defer_not_ready", rdy, 0);
    check("defer_no_accept", acc_cnt - a0, 0);
    dev_clk = 1'b1;
    n = 0;
    while (!tx_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("defer_started", tx_busy, 1);
    tx_data = 8'hFF;
    wait_release();
    dev_run(11, 1'b1, bits);
    tx_valid = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("defer_bits", bits, 10'h201);
    check("defer_single_accept", acc_cnt - a0, 1);
    check("defer_done", done_cnt - d0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: the send side of the keyboard link whose receive side feeds `keyCode`/`make`/`brake` to the game. It accepts one command byte through a valid/ready handshake and runs the full PS/2 host request: clock inhibit, start, 8 data bits LSB-first, odd parity, stop, and device ACK. It drives the shared open-drain PS2_CLK/PS2_DAT lines through output-enable signals and reports completion or error. `tx_busy` gates the keyboard receiver so it ignores the bus while a transmit is in progress.

## Interface
- `CLK_FREQ_HZ`, 50_000_000, system clock frequency.
- `INHIBIT_CYCLES`, 5_000, time CLK is held low before the request (100 µs).
- `REQ_CYCLES`, 250, time CLK and DAT are both held low before CLK is released (5 µs).
- `TIMEOUT_CYCLES`, 750_000, maximum gap allowed between device clock falling edges, and from CLK release to the first falling edge (15 ms).
- `FILTER_LEN`, 8, number of consecutive equal samples needed to change a filtered line value.

- `clk` in 1: system clock (CLOCK_50).
- `reset` in 1: synchronous, active-high reset.
- `tx_data` in 8: command byte to send.
- `tx_valid` in 1: a command is offered.
- `tx_ready` out 1: the block can accept a command.
- `ps2_clk_in` in 1: raw PS2_CLK pad input (asynchronous).
- `ps2_dat_in` in 1: raw PS2_DAT pad input (asynchronous).
- `ps2_clk_oe` out 1: 1 = drive PS2_CLK low; 0 = release the line.
- `ps2_dat_oe` out 1: 1 = drive PS2_DAT low; 0 = release the line.
- `tx_busy` out 1: a transmit is in progress; the receiver ignores the bus while this is high.
- `tx_done` out 1: one-cycle pulse when the device has ACKed and the bus is idle again.
- `tx_err` out 1: one-cycle pulse on a failed transmit.
- `err_code` out 2: `01` = timeout, `10` = no ACK. Holds its value until the next accepted command.

## Operation
- Both raw inputs pass through a 2-FF synchronizer and then a FILTER_LEN-sample filter. `clk_fall` is a one-cycle strobe generated when the filtered CLK goes from 1 to 0.
- Frame word: {stop=1, parity = ~^tx_data, tx_data[7:0]}. It is shifted out LSB-first.
- States and transitions:
  - IDLE: `tx_ready` = filtered CLK & filtered DAT. When `tx_valid & tx_ready`, latch the frame word, clear `err_code`, go to INHIBIT.
  - INHIBIT: `clk_oe=1`, `dat_oe=0` for INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: `clk_oe=1`, `dat_oe=1` for REQ_CYCLES cycles, then go to SEND. `dat_oe=1` here is the start bit.
  - SEND: `clk_oe=0`. On each `clk_fall`, `dat_oe = ~shift[0]` and the shift register moves right. Falling edges 1–8 present data bits 0–7, edge 9 presents parity, edge 10 presents stop (line released). After edge 10, go to ACK.
  - ACK: on the 11th `clk_fall`, sample filtered DAT. If 0, go to WAIT_IDLE. If 1, raise a no-ACK error.
  - WAIT_IDLE: wait until filtered CLK and filtered DAT are both 1, then pulse `tx_done` and go to IDLE.
- Timeout counter: reset on entry to SEND and on every `clk_fall`; active in SEND, ACK and WAIT_IDLE. Reaching TIMEOUT_CYCLES raises a timeout error.
- Error handling: set `err_code`, pulse `tx_err`, release both lines, go to IDLE.
- `tx_busy` = (state != IDLE).
- Extra `tx_valid` while busy: ignored, since `tx_ready`=0. `tx_valid` while the device is mid-frame (filtered CLK low in IDLE): deferred, since `tx_ready`=0.

## Timing
- Reset values: `ps2_clk_oe`=0, `ps2_dat_oe`=0, `tx_ready`=0 (then follows filtered bus state from IDLE), `tx_busy`=0, `tx_done`=0, `tx_err`=0, `err_code`=00. Filters reset to 1 (idle bus).
- Reset asserted mid-frame: both lines are released on the first clock edge with `reset` high; no `tx_done` or `tx_err` is generated.
- All outputs are registered.
- `clk_oe` rises the cycle after the accept.
- `dat_oe` changes 1 cycle after `clk_fall`, which itself lags the pad by 2 + FILTER_LEN cycles. This is ≤ 0.2 µs, well inside the ~30 µs clock-low phase.
- The accept-to-CLK-release interval is exactly INHIBIT_CYCLES + REQ_CYCLES cycles.
- `tx_done` is asserted 1 cycle after both filtered lines read high in WAIT_IDLE.
- Counter widths are $clog2 of their limits. Parity is computed at latch time.

## Structure
- Shared package `ps2_pkg`:
  - state enum;
  - `err_code` constants (ERR_NONE, ERR_TIMEOUT, ERR_NOACK);
  - command constants (CMD_SET_LEDS = 8'hED, CMD_ENABLE = 8'hF4, CMD_RESET = 8'hFF);
  - the shared default timing constants.
- Sub-module `ps2_line_filter`: synchronizer plus majority-free run-length filter with a fall-edge strobe output. Instantiated once for CLK and once for DAT; the keyboard receiver can reuse it.

## Test plan
- Send 8'hED with a device model that ACKs:
  - CLK is held low 5000 cycles, then DAT also low for 250 cycles, then CLK is released.
  - Bits sampled on device rising edges are 1,0,1,1,0,1,1,1, parity = 1, stop = 1.
  - `tx_done` pulses once; `err_code` = 00.
- Send 8'h00: parity bit = 1. Send 8'h01: parity bit = 0.
- Device never clocks: `tx_err` pulses exactly 750_000 cycles after CLK release, `err_code` = 01, both OE = 0.
- Device leaves DAT high on the 11th edge: `tx_err` pulses, `err_code` = 10, no `tx_done`.
- Assert `reset` during the data phase (after edge 4): `ps2_clk_oe` = `ps2_dat_oe` = 0 on the next cycle, then a clean 8'hF4 transfer completes.
- Hold `tx_valid` while the device holds CLK low: `tx_ready` stays 0. After the bus idles, the transfer starts. A second `tx_valid` during the transfer is not accepted.
